// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch stage: the NOP encoding
// placed on idle and stall slots, and the fetch FSM state encoding.
package ifetch_pkg;

    localparam logic [19:0] NOP_INSTR = 20'h00000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        PAUSE = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_prog_mem.sv
// Program memory for the fetch stage: 2^PC_BITS words, synchronous write,
// registered read, contents deliberately not reset so a program survives rst.
module prog_mem #(
    parameter int INSTR_WIDTH = 20,
    parameter int PC_BITS     = 5
) (
    input  logic                   clk,
    input  logic                   wen,
    input  logic [PC_BITS-1:0]     waddr,
    input  logic [INSTR_WIDTH-1:0] wdata,
    input  logic                   ren,
    input  logic [PC_BITS-1:0]     raddr,
    output logic [INSTR_WIDTH-1:0] rdata
);

    logic [INSTR_WIDTH-1:0] mem [2**PC_BITS];

    // Write port: store one program word per strobe.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: the read register only updates on a real fetch, so a stalled
    // slot never disturbs the last issued word.
    always_ff @(posedge clk) begin
        if (ren) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage feeding simple_cpu. Holds the program memory, PC
// and fetch FSM; issues one word per unstalled cycle, NOP otherwise.
// Optional breakpoint/PAUSE support is enabled by defining IFETCH_BREAKPOINT_EN.
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter int INSTR_WIDTH = 20,
    parameter int PC_BITS     = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   prog_wen,
    input  logic [PC_BITS-1:0]     prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    input  logic                   start,
    input  logic [PC_BITS-1:0]     last_addr,
    input  logic                   stall,
`ifdef IFETCH_BREAKPOINT_EN
    input  logic                   bp_en,
    input  logic [PC_BITS-1:0]     bp_addr,
    output logic                   bp_hit,
`endif
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instr_valid,
    output logic [PC_BITS-1:0]     pc,
    output logic                   busy,
    output logic                   done
);

    localparam logic [INSTR_WIDTH-1:0] NOP_W = INSTR_WIDTH'(NOP_INSTR);

    fetch_state_t           state;
    logic [PC_BITS-1:0]     last_q;
    logic                   valid_q;
    logic                   done_q;
    logic                   fetch_en;
    logic                   mem_wen;
    logic                   bp_trip;
    logic [INSTR_WIDTH-1:0] mem_rdata;

`ifdef IFETCH_BREAKPOINT_EN
    logic resume_q;

    // The fetch right after a resume must not re-trip the breakpoint that
    // caused the pause; the flag clears once that fetch has actually issued.
    always_ff @(posedge clk) begin
        if (!rst) begin
            resume_q <= 1'b0;
        end else if (state == PAUSE && start) begin
            resume_q <= 1'b1;
        end else if (fetch_en) begin
            resume_q <= 1'b0;
        end
    end

    assign bp_trip = bp_en && (pc == bp_addr) && !resume_q;
    assign bp_hit  = (state == PAUSE);
`else
    assign bp_trip = 1'b0;
`endif

    assign fetch_en = (state == RUN) && !stall && !bp_trip;
    assign mem_wen  = (state == IDLE) && prog_wen;

    prog_mem #(
        .INSTR_WIDTH(INSTR_WIDTH),
        .PC_BITS    (PC_BITS)
    ) u_prog_mem (
        .clk  (clk),
        .wen  (mem_wen),
        .waddr(prog_addr),
        .wdata(prog_data),
        .ren  (fetch_en),
        .raddr(pc),
        .rdata(mem_rdata)
    );

    // FSM, PC counter and the valid/done output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            pc      <= '0;
            last_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= fetch_en;
            done_q  <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        pc     <= '0;
                        last_q <= last_addr;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        if (bp_trip) begin
                            state <= PAUSE;
                        end else if (pc == last_q) begin
                            state <= DONE;
                        end else begin
                            pc <= pc + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
`ifdef IFETCH_BREAKPOINT_EN
                PAUSE: begin
                    if (start) begin
                        state <= RUN;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The word register is only meaningful while valid, so idle and stall
    // slots are masked to NOP for the CPU, which has no qualifier of its own.
    assign instruction = valid_q ? mem_rdata : NOP_W;
    assign instr_valid = valid_q;
    assign done        = done_q;
    assign busy        = (state != IDLE) || done_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch. Expected words are queued from a local
// memory model when a run is started and popped as the DUT issues them.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_wen;
    logic [4:0]  prog_addr;
    logic [19:0] prog_data;
    logic        start;
    logic [4:0]  last_addr;
    logic        stall;
    logic [19:0] instruction;
    logic        instr_valid;
    logic [4:0]  pc;
    logic        busy;
    logic        done;
`ifdef IFETCH_BREAKPOINT_EN
    logic        bp_en;
    logic [4:0]  bp_addr;
    logic        bp_hit;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [19:0] mem_model [32];
    logic [19:0] exp_q [$];

    instr_fetch #(.INSTR_WIDTH(20), .PC_BITS(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .prog_wen   (prog_wen),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .start      (start),
        .last_addr  (last_addr),
        .stall      (stall),
`ifdef IFETCH_BREAKPOINT_EN
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .bp_hit     (bp_hit),
`endif
        .instruction(instruction),
        .instr_valid(instr_valid),
        .pc         (pc),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic load_word(input logic [4:0] addr, input logic [19:0] data);
        prog_wen  = 1'b1;
        prog_addr = addr;
        prog_data = data;
        tick();
        prog_wen  = 1'b0;
        mem_model[addr] = data;
    endtask

    // Pulse start (optionally with a same-edge write) and queue the words
    // the run is expected to issue.
    task automatic applyStimulus(input logic [4:0] last, input bit with_write,
                                 input logic [4:0] waddr, input logic [19:0] wdata);
        if (with_write) begin
            prog_wen  = 1'b1;
            prog_addr = waddr;
            prog_data = wdata;
            mem_model[waddr] = wdata;
        end
        for (int i = 0; i <= int'(last); i++) exp_q.push_back(mem_model[i]);
        start     = 1'b1;
        last_addr = last;
        tick();
        start     = 1'b0;
        prog_wen  = 1'b0;
        last_addr = 5'd0;
        checkOutput("start_busy", busy, 1);
        checkOutput("start_pc", pc, 0);
        checkOutput("start_latency_nop", instruction, 20'h00000);
    endtask

    // Step the run until done, comparing issued words with the queue.
    // Optional stall burst after stall_at words, optional disturbance of
    // prog_wen/start during the first cycles.
    task automatic collect(input int budget, input int stall_at, input int stall_len,
                           input bit disturb, output int done_cycle);
        int words_seen = 0;
        int stall_used = 0;
        int done_count = 0;
        done_cycle = -1;
        for (int c = 1; c <= budget; c++) begin
            if (words_seen >= stall_at && stall_used < stall_len) begin
                stall = 1'b1;
                stall_used++;
            end else begin
                stall = 1'b0;
            end
            if (disturb && c <= 2) begin
                prog_wen  = 1'b1;
                prog_addr = 5'd1;
                prog_data = 20'hABCDE;
                start     = 1'b1;
                last_addr = 5'd31;
            end else begin
                prog_wen  = 1'b0;
                start     = 1'b0;
                last_addr = 5'd0;
            end
            tick();
            if (instr_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_word", instr_valid, 0);
                end else begin
                    checkOutput("word", instruction, exp_q.pop_front());
                    words_seen++;
                end
            end else begin
                checkOutput("idle_nop", instruction, 20'h00000);
            end
            if (done) begin
                done_count++;
                done_cycle = c;
                checkOutput("done_busy", busy, 1);
                break;
            end
        end
        stall    = 1'b0;
        prog_wen = 1'b0;
        start    = 1'b0;
        checkOutput("done_seen", done_count, 1);
        checkOutput("words_left", exp_q.size(), 0);
        exp_q.delete();
        tick();
        checkOutput("after_busy", busy, 0);
        checkOutput("after_done", done, 0);
        checkOutput("after_nop", instruction, 20'h00000);
    endtask

    initial begin
        int dc;
        rst       = 1'b0;
        prog_wen  = 1'b0;
        prog_addr = 5'd0;
        prog_data = 20'h0;
        start     = 1'b0;
        last_addr = 5'd0;
        stall     = 1'b0;
`ifdef IFETCH_BREAKPOINT_EN
        bp_en     = 1'b0;
        bp_addr   = 5'd0;
`endif
        tick();
        tick();
        checkOutput("rst_instr", instruction, 20'h00000);
        checkOutput("rst_valid", instr_valid, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_pc", pc, 0);
        rst = 1'b1;
        tick();

        $display("[TB] basic four-word program");
        load_word(5'd0, 20'h11111);
        load_word(5'd1, 20'h22222);
        load_word(5'd2, 20'h33333);
        load_word(5'd3, 20'h44444);
        applyStimulus(5'd3, 1'b0, 5'd0, 20'h0);
        collect(20, 99, 0, 1'b0, dc);
        checkOutput("basic_done_cycle", dc, 5);

        $display("[TB] two-cycle stall after second word");
        applyStimulus(5'd3, 1'b0, 5'd0, 20'h0);
        collect(20, 2, 2, 1'b0, dc);
        checkOutput("stall_done_cycle", dc, 7);

        $display("[TB] full 32-word program");
        for (int i = 0; i < 32; i++) load_word(5'(i), 20'h5A000 ^ 20'(i * 37 + 1));
        applyStimulus(5'd31, 1'b0, 5'd0, 20'h0);
        collect(60, 99, 0, 1'b0, dc);
        checkOutput("full_done_cycle", dc, 33);
        checkOutput("full_pc_end", pc, 31);

        $display("[TB] reset mid-run");
        start     = 1'b1;
        last_addr = 5'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10 && pc != 5'd2; i++) tick();
        checkOutput("reach_pc2", pc, 2);
        rst = 1'b0;
        tick();
        checkOutput("midrst_instr", instruction, 20'h00000);
        checkOutput("midrst_valid", instr_valid, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_pc", pc, 0);
        checkOutput("midrst_done", done, 0);
        rst = 1'b1;
        tick();
        applyStimulus(5'd3, 1'b0, 5'd0, 20'h0);
        collect(20, 99, 0, 1'b0, dc);
        checkOutput("restart_done_cycle", dc, 5);

        $display("[TB] prog_wen and start ignored during run");
        applyStimulus(5'd3, 1'b0, 5'd0, 20'h0);
        collect(20, 99, 0, 1'b1, dc);
        checkOutput("disturb_done_cycle", dc, 5);
        applyStimulus(5'd3, 1'b0, 5'd0, 20'h0);
        collect(20, 99, 0, 1'b0, dc);
        checkOutput("after_disturb_done_cycle", dc, 5);

        $display("[TB] same-edge write to address 0 with start, single word");
        applyStimulus(5'd0, 1'b1, 5'd0, 20'h0F0F0);
        collect(10, 99, 0, 1'b0, dc);
        checkOutput("single_done_cycle", dc, 2);

`ifdef IFETCH_BREAKPOINT_EN
        $display("[TB] breakpoint at address 2");
        bp_en   = 1'b1;
        bp_addr = 5'd2;
        exp_q.push_back(mem_model[0]);
        exp_q.push_back(mem_model[1]);
        start     = 1'b1;
        last_addr = 5'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10 && !bp_hit; i++) begin
            tick();
            if (instr_valid && exp_q.size() != 0) checkOutput("bp_word", instruction, exp_q.pop_front());
        end
        checkOutput("bp_hit", bp_hit, 1);
        checkOutput("bp_words_left", exp_q.size(), 0);
        checkOutput("bp_pc", pc, 2);
        checkOutput("bp_valid", instr_valid, 0);
        tick();
        tick();
        checkOutput("bp_hold", bp_hit, 1);
        checkOutput("bp_hold_nop", instruction, 20'h00000);
        exp_q.push_back(mem_model[2]);
        exp_q.push_back(mem_model[3]);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("bp_resume_clear", bp_hit, 0);
        collect(10, 99, 0, 1'b0, dc);
        checkOutput("bp_done_cycle", dc, 3);
        bp_en = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
